// File: rtl/fpnew_divsqrt_lane_dispatch.sv
// -----------------------------------------------------------------------------
// fpnew_divsqrt_lane_dispatch
//
// Dispatch/retire controller for NumLanes iterative div/sqrt units. Accepts one
// op per cycle and starts it on a free lane in the same cycle. Each lane keeps
// its result/status/tag/aux until downstream takes them. Results retire in
// issue order (InOrder=1) or lowest-index-completed-first (InOrder=0).
//
// Ports
//   clk_i, rst_ni                 clock, async active-low reset
//   operands_i, is_div_i, fmt_i, rnd_mode_i, tag_i, aux_i,
//   in_valid_i / in_ready_o       issue handshake
//   flush_i                       kill all in-flight work (mirrored on unit_kill_o)
//   unit_div_start_o / unit_sqrt_start_o   one-hot start pulses per lane
//   unit_operands_o, unit_fmt_o, unit_rnd_o  broadcast to every lane
//   unit_ready_i, unit_done_i, unit_result_i, unit_status_i  per-lane unit side
//   result_o, status_o, tag_o, aux_o, out_valid_o / out_ready_i  retire handshake
//   busy_o                        any lane BUSY or HOLD
// -----------------------------------------------------------------------------
module fpnew_divsqrt_lane_dispatch #(
  parameter int unsigned NumLanes = 2,
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned TagWidth = 2,
  parameter int unsigned AuxWidth = 2,
  parameter bit          InOrder  = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [2*WIDTH-1:0]        operands_i,
  input  logic                      is_div_i,
  input  logic [1:0]                fmt_i,
  input  logic [2:0]                rnd_mode_i,
  input  logic [TagWidth-1:0]       tag_i,
  input  logic [AuxWidth-1:0]       aux_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic                      flush_i,
  output logic [NumLanes-1:0]       unit_div_start_o,
  output logic [NumLanes-1:0]       unit_sqrt_start_o,
  output logic [2*WIDTH-1:0]        unit_operands_o,
  output logic [1:0]                unit_fmt_o,
  output logic [2:0]                unit_rnd_o,
  output logic                      unit_kill_o,
  input  logic [NumLanes-1:0]       unit_ready_i,
  input  logic [NumLanes-1:0]       unit_done_i,
  input  logic [NumLanes*WIDTH-1:0] unit_result_i,
  input  logic [NumLanes*5-1:0]     unit_status_i,
  output logic [WIDTH-1:0]          result_o,
  output logic [4:0]                status_o,
  output logic [TagWidth-1:0]       tag_o,
  output logic [AuxWidth-1:0]       aux_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic                      busy_o
);

  localparam int unsigned PtrW = (NumLanes > 1) ? $clog2(NumLanes) : 1;
  typedef logic [PtrW-1:0] ptr_t;

  typedef enum logic [1:0] {
    LANE_IDLE,
    LANE_BUSY,
    LANE_HOLD
  } lane_state_e;

  lane_state_e         state_q [NumLanes];
  lane_state_e         state_d [NumLanes];
  logic [WIDTH-1:0]    hold_result_q [NumLanes];
  logic [4:0]          hold_status_q [NumLanes];
  logic [TagWidth-1:0] tag_q [NumLanes];
  logic [AuxWidth-1:0] aux_q [NumLanes];
  logic [WIDTH-1:0]    lane_result [NumLanes];
  logic [4:0]          lane_status [NumLanes];
  ptr_t                issue_ptr_q, ret_ptr_q;

  logic                active;
  logic [NumLanes-1:0] done_vld, cand_mask, retire_mask, free_mask, start_mask;
  logic                cand_found, retire, tgt_free, start;
  ptr_t                cand_idx, tgt_idx;

  function automatic ptr_t next_ptr(input ptr_t p);
    if (p == ptr_t'(NumLanes - 1)) return '0;
    return p + ptr_t'(1);
  endfunction

  // Reset is folded in so the handshake outputs drop the moment rst_ni falls,
  // not at the next edge.
  assign active          = rst_ni & ~flush_i;
  assign unit_kill_o     = flush_i;
  assign unit_operands_o = operands_i;
  assign unit_fmt_o      = fmt_i;
  assign unit_rnd_o      = rnd_mode_i;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    done_vld    = '0;
    cand_mask   = '0;
    retire_mask = '0;
    free_mask   = '0;
    start_mask  = '0;
    cand_found  = 1'b0;
    cand_idx    = '0;
    tgt_free    = 1'b0;
    tgt_idx     = '0;
    result_o    = '0;
    status_o    = '0;
    tag_o       = '0;
    aux_o       = '0;

    for (int i = 0; i < NumLanes; i++) begin
      lane_result[i] = unit_result_i[i*WIDTH +: WIDTH];
      lane_status[i] = unit_status_i[i*5 +: 5];
      // A done pulse only counts on a lane that is actually computing.
      done_vld[i]  = unit_done_i[i] & (state_q[i] == LANE_BUSY) & active;
      cand_mask[i] = done_vld[i] | ((state_q[i] == LANE_HOLD) & active);
    end

    // Retire selection.
    if (InOrder) begin
      cand_idx   = ret_ptr_q;
      cand_found = cand_mask[ret_ptr_q];
    end else begin
      for (int i = int'(NumLanes) - 1; i >= 0; i--) begin
        if (cand_mask[i]) begin
          cand_found = 1'b1;
          cand_idx   = ptr_t'(i);
        end
      end
    end

    out_valid_o = cand_found;
    retire      = cand_found & out_ready_i;
    if (retire) retire_mask[cand_idx] = 1'b1;

    // A lane retiring this cycle is free again, which gives full throughput
    // when issue and retire land on the same lane.
    for (int i = 0; i < NumLanes; i++) begin
      free_mask[i] = (state_q[i] == LANE_IDLE) | retire_mask[i];
    end

    if (InOrder) begin
      tgt_idx  = issue_ptr_q;
      tgt_free = free_mask[issue_ptr_q];
    end else begin
      for (int i = int'(NumLanes) - 1; i >= 0; i--) begin
        if (free_mask[i]) begin
          tgt_free = 1'b1;
          tgt_idx  = ptr_t'(i);
        end
      end
    end

    in_ready_o = tgt_free & unit_ready_i[tgt_idx] & active;
    start      = in_valid_i & in_ready_o;
    if (start) start_mask[tgt_idx] = 1'b1;

    // Data for a lane finishing this cycle bypasses the hold registers.
    if (cand_found) begin
      if (done_vld[cand_idx]) begin
        result_o = lane_result[cand_idx];
        status_o = lane_status[cand_idx];
      end else begin
        result_o = hold_result_q[cand_idx];
        status_o = hold_status_q[cand_idx];
      end
      tag_o = tag_q[cand_idx];
      aux_o = aux_q[cand_idx];
    end

    busy_o = 1'b0;
    for (int i = 0; i < NumLanes; i++) begin
      state_d[i] = state_q[i];
      if (state_q[i] != LANE_IDLE) busy_o = 1'b1;
      unique case (state_q[i])
        LANE_IDLE: ;
        LANE_BUSY: if (done_vld[i]) state_d[i] = retire_mask[i] ? LANE_IDLE : LANE_HOLD;
        LANE_HOLD: if (retire_mask[i]) state_d[i] = LANE_IDLE;
        default:   state_d[i] = LANE_IDLE;
      endcase
      if (start_mask[i]) state_d[i] = LANE_BUSY;
      if (flush_i)       state_d[i] = LANE_IDLE;
    end
    busy_o = busy_o & active;
  end

  assign unit_div_start_o  = is_div_i ? start_mask : '0;
  assign unit_sqrt_start_o = is_div_i ? '0 : start_mask;

  // NOTE: state is registered with non-blocking assignments so every flop
  // samples the pre-edge value regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumLanes; i++) state_q[i] <= LANE_IDLE;
      issue_ptr_q <= '0;
      ret_ptr_q   <= '0;
    end else begin
      for (int i = 0; i < NumLanes; i++) state_q[i] <= state_d[i];
      if (flush_i) begin
        issue_ptr_q <= '0;
        ret_ptr_q   <= '0;
      end else begin
        if (start)            issue_ptr_q <= next_ptr(issue_ptr_q);
        if (retire && InOrder) ret_ptr_q  <= next_ptr(ret_ptr_q);
      end
    end
  end

  // NOTE: the per-lane data registers carry no reset; they are only read while
  // the lane state says they hold valid data, and the state itself is reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NumLanes; i++) begin
      if (done_vld[i]) begin
        hold_result_q[i] <= lane_result[i];
        hold_status_q[i] <= lane_status[i];
      end
      if (start_mask[i]) begin
        tag_q[i] <= tag_i;
        aux_q[i] <= aux_i;
      end
    end
  end

endmodule

// File: tb/tb_fpnew_divsqrt_lane_dispatch.sv
// -----------------------------------------------------------------------------
// Testbench for fpnew_divsqrt_lane_dispatch. Two instances share all inputs:
// u_io (InOrder=1) and u_oo (InOrder=0). Expected retire data goes into one
// queue per instance and is compared when that instance presents an output.
// -----------------------------------------------------------------------------
module tb_fpnew_divsqrt_lane_dispatch;

  localparam int W = 64;

  typedef struct packed {
    logic [1:0]   tag;
    logic [1:0]   aux;
    logic [W-1:0] result;
    logic [4:0]   status;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_ni;
  logic [2*W-1:0] operands;
  logic           is_div;
  logic [1:0]     fmt;
  logic [2:0]     rnd_mode;
  logic [1:0]     tag, aux;
  logic           in_valid, flush, out_ready;
  logic [1:0]     unit_ready, unit_done;
  logic [2*W-1:0] unit_result;
  logic [9:0]     unit_status;

  logic           io_in_ready, oo_in_ready, io_kill, oo_kill;
  logic [1:0]     io_div_start, io_sqrt_start, oo_div_start, oo_sqrt_start;
  logic [2*W-1:0] io_ops, oo_ops;
  logic [1:0]     io_fmt, oo_fmt;
  logic [2:0]     io_rnd, oo_rnd;
  logic [W-1:0]   io_result, oo_result;
  logic [4:0]     io_status, oo_status;
  logic [1:0]     io_tag, oo_tag, io_aux, oo_aux;
  logic           io_out_valid, oo_out_valid, io_busy, oo_busy;

  int   checks = 0;
  int   failures = 0;
  exp_t q_io[$];
  exp_t q_oo[$];

  always #5 clk = ~clk;

  fpnew_divsqrt_lane_dispatch #(.NumLanes(2), .WIDTH(W), .TagWidth(2), .AuxWidth(2), .InOrder(1'b1)) u_io (
    .clk_i(clk), .rst_ni(rst_ni), .operands_i(operands), .is_div_i(is_div), .fmt_i(fmt),
    .rnd_mode_i(rnd_mode), .tag_i(tag), .aux_i(aux), .in_valid_i(in_valid), .in_ready_o(io_in_ready),
    .flush_i(flush), .unit_div_start_o(io_div_start), .unit_sqrt_start_o(io_sqrt_start),
    .unit_operands_o(io_ops), .unit_fmt_o(io_fmt), .unit_rnd_o(io_rnd), .unit_kill_o(io_kill),
    .unit_ready_i(unit_ready), .unit_done_i(unit_done), .unit_result_i(unit_result),
    .unit_status_i(unit_status), .result_o(io_result), .status_o(io_status), .tag_o(io_tag),
    .aux_o(io_aux), .out_valid_o(io_out_valid), .out_ready_i(out_ready), .busy_o(io_busy));

  fpnew_divsqrt_lane_dispatch #(.NumLanes(2), .WIDTH(W), .TagWidth(2), .AuxWidth(2), .InOrder(1'b0)) u_oo (
    .clk_i(clk), .rst_ni(rst_ni), .operands_i(operands), .is_div_i(is_div), .fmt_i(fmt),
    .rnd_mode_i(rnd_mode), .tag_i(tag), .aux_i(aux), .in_valid_i(in_valid), .in_ready_o(oo_in_ready),
    .flush_i(flush), .unit_div_start_o(oo_div_start), .unit_sqrt_start_o(oo_sqrt_start),
    .unit_operands_o(oo_ops), .unit_fmt_o(oo_fmt), .unit_rnd_o(oo_rnd), .unit_kill_o(oo_kill),
    .unit_ready_i(unit_ready), .unit_done_i(unit_done), .unit_result_i(unit_result),
    .unit_status_i(unit_status), .result_o(oo_result), .status_o(oo_status), .tag_o(oo_tag),
    .aux_o(oo_aux), .out_valid_o(oo_out_valid), .out_ready_i(out_ready), .busy_o(oo_busy));

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] t, input logic [1:0] a,
                              input logic [W-1:0] r, input logic [4:0] s);
    exp_t e;
    e.tag = t; e.aux = a; e.result = r; e.status = s;
    return e;
  endfunction

  // Compares one instance's output port set against the scoreboard head and
  // pops it when the handshake completes.
  task automatic check_out(input string name, input bit dut_oo, input bit exp_valid);
    logic v; logic [W-1:0] r; logic [4:0] s; logic [1:0] t, a; exp_t e; int sz;
    if (dut_oo) begin
      v = oo_out_valid; r = oo_result; s = oo_status; t = oo_tag; a = oo_aux; sz = q_oo.size();
    end else begin
      v = io_out_valid; r = io_result; s = io_status; t = io_tag; a = io_aux; sz = q_io.size();
    end
    check({name, ".valid"}, 64'(v), 64'(exp_valid));
    if (!exp_valid) begin
      check({name, ".zero_result"}, r, 64'd0);
      check({name, ".zero_tag"}, 64'(t), 64'd0);
    end else if (sz == 0) begin
      checks++; failures++;
      $error("FAIL %s.sb: output expected but scoreboard empty", name);
    end else begin
      e = dut_oo ? q_oo[0] : q_io[0];
      check({name, ".result"}, r, e.result);
      check({name, ".status"}, 64'(s), 64'(e.status));
      check({name, ".tag"}, 64'(t), 64'(e.tag));
      check({name, ".aux"}, 64'(a), 64'(e.aux));
      if (out_ready) begin
        if (dut_oo) void'(q_oo.pop_front());
        else        void'(q_io.pop_front());
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  localparam logic [W-1:0] GARB = 64'hDEAD_BEEF_DEAD_BEEF;

  initial begin
    rst_ni = 1'b0; operands = {64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000};
    is_div = 1'b0; fmt = 2'b10; rnd_mode = 3'b011; tag = '0; aux = '0; in_valid = 1'b0;
    flush = 1'b0; out_ready = 1'b1; unit_ready = 2'b11; unit_done = '0;
    unit_result = {GARB, GARB}; unit_status = '1;

    // Reset state.
    #2;
    check("rst.io_in_ready", 64'(io_in_ready), 64'd0);
    check("rst.oo_in_ready", 64'(oo_in_ready), 64'd0);
    check("rst.io_busy", 64'(io_busy), 64'd0);
    check("rst.io_starts", 64'({io_div_start, io_sqrt_start}), 64'd0);
    check_out("rst.io", 1'b0, 1'b0);
    check_out("rst.oo", 1'b1, 1'b0);
    next_cycle(); next_cycle();
    rst_ni = 1'b1;

    // Test 1/2: div tag0 then sqrt tag1 back to back.
    in_valid = 1'b1; is_div = 1'b1; tag = 2'd0; aux = 2'd1;
    @(negedge clk);
    check("t1.io_in_ready", 64'(io_in_ready), 64'd1);
    check("t1.io_div_start", 64'(io_div_start), 64'd1);
    check("t1.io_sqrt_start", 64'(io_sqrt_start), 64'd0);
    check("t1.oo_div_start", 64'(oo_div_start), 64'd1);
    check("t1.operands", io_ops[63:0], 64'h3FF0_0000_0000_0000);
    check("t1.fmt_rnd", 64'({io_fmt, io_rnd}), 64'({2'b10, 3'b011}));
    check("t1.kill_idle", 64'(io_kill), 64'd0);
    q_io.push_back(mk(2'd0, 2'd1, 64'h0000_0000_0000_00A0, 5'h01));
    next_cycle();
    is_div = 1'b0; tag = 2'd1; aux = 2'd2;
    @(negedge clk);
    check("t1.io_sqrt_start", 64'(io_sqrt_start), 64'd2);
    check("t1.oo_sqrt_start", 64'(oo_sqrt_start), 64'd2);
    check("t1.io_div_start0", 64'(io_div_start), 64'd0);
    q_io.push_back(mk(2'd1, 2'd2, 64'h0000_0000_0000_00B1, 5'h02));
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    check("t1.io_busy", 64'(io_busy), 64'd1);
    check("t1.io_in_ready_full", 64'(io_in_ready), 64'd0);
    check("t1.oo_in_ready_full", 64'(oo_in_ready), 64'd0);
    check_out("t1.io_wait", 1'b0, 1'b0);
    check_out("t1.oo_wait", 1'b1, 1'b0);
    repeat (5) next_cycle();

    // Lane 1 finishes first.
    unit_done = 2'b10; unit_result = {64'h0000_0000_0000_00B1, GARB}; unit_status = {5'h02, 5'h1F};
    q_oo.push_back(mk(2'd1, 2'd2, 64'h0000_0000_0000_00B1, 5'h02));
    @(negedge clk);
    check_out("t1.io_lane1_early", 1'b0, 1'b0);
    check_out("t2.oo_lane1_first", 1'b1, 1'b1);
    next_cycle();
    unit_done = 2'b00; unit_result = {GARB, GARB};
    @(negedge clk);
    check_out("t1.io_hold_wait", 1'b0, 1'b0);
    check_out("t2.oo_empty", 1'b1, 1'b0);
    check("t1.io_busy_hold", 64'(io_busy), 64'd1);
    repeat (3) next_cycle();

    // Lane 0 finishes while downstream stalls for three cycles.
    unit_done = 2'b01; unit_result = {GARB, 64'h0000_0000_0000_00A0}; unit_status = {5'h1F, 5'h01};
    out_ready = 1'b0;
    q_oo.push_back(mk(2'd0, 2'd1, 64'h0000_0000_0000_00A0, 5'h01));
    @(negedge clk);
    check_out("t1.io_lane0_pass", 1'b0, 1'b1);
    check_out("t2.oo_lane0_pass", 1'b1, 1'b1);
    next_cycle();
    unit_done = 2'b00; unit_result = {GARB, GARB}; unit_status = '1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_out("t2.io_stable", 1'b0, 1'b1);
      check_out("t2.oo_stable", 1'b1, 1'b1);
      check("t2.io_in_ready_hold", 64'(io_in_ready), 64'd0);
      check("t2.oo_in_ready_lane1", 64'(oo_in_ready), 64'd1);
      next_cycle();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_out("t1.io_tag0", 1'b0, 1'b1);
    check_out("t2.oo_tag0", 1'b1, 1'b1);
    next_cycle();
    @(negedge clk);
    check_out("t1.io_tag1_from_hold", 1'b0, 1'b1);
    check_out("t2.oo_done", 1'b1, 1'b0);
    next_cycle();

    // Test 3: both lanes busy, retire lane 0 while a new op is waiting.
    in_valid = 1'b1; is_div = 1'b1; tag = 2'd2; aux = 2'd0;
    q_io.push_back(mk(2'd2, 2'd0, 64'h0000_0000_0000_00C2, 5'h04));
    next_cycle();
    is_div = 1'b0; tag = 2'd3; aux = 2'd1;
    q_io.push_back(mk(2'd3, 2'd1, 64'h0000_0000_0000_00D3, 5'h08));
    next_cycle();
    is_div = 1'b1; tag = 2'd0; aux = 2'd3;
    unit_done = 2'b01; unit_result = {GARB, 64'h0000_0000_0000_00C2}; unit_status = {5'h1F, 5'h04};
    q_io.push_back(mk(2'd0, 2'd3, 64'h0000_0000_0000_00E0, 5'h10));
    q_oo.push_back(mk(2'd2, 2'd0, 64'h0000_0000_0000_00C2, 5'h04));
    @(negedge clk);
    check("t3.io_in_ready_reuse", 64'(io_in_ready), 64'd1);
    check("t3.io_div_start_wrap", 64'(io_div_start), 64'd1);
    check("t3.oo_div_start", 64'(oo_div_start), 64'd1);
    check_out("t3.io_retire_lane0", 1'b0, 1'b1);
    check_out("t3.oo_retire_lane0", 1'b1, 1'b1);
    next_cycle();
    in_valid = 1'b0;
    unit_done = 2'b10; unit_result = {64'h0000_0000_0000_00D3, GARB}; unit_status = {5'h08, 5'h1F};
    q_oo.push_back(mk(2'd3, 2'd1, 64'h0000_0000_0000_00D3, 5'h08));
    @(negedge clk);
    check_out("t3.io_lane1", 1'b0, 1'b1);
    check_out("t3.oo_lane1", 1'b1, 1'b1);
    next_cycle();
    unit_done = 2'b01; unit_result = {GARB, 64'h0000_0000_0000_00E0}; unit_status = {5'h1F, 5'h10};
    q_oo.push_back(mk(2'd0, 2'd3, 64'h0000_0000_0000_00E0, 5'h10));
    @(negedge clk);
    check_out("t3.io_new_op", 1'b0, 1'b1);
    check_out("t3.oo_new_op", 1'b1, 1'b1);
    next_cycle();
    unit_done = 2'b00;

    // Test 4: flush with both lanes busy and a done pulse in the same cycle.
    in_valid = 1'b1; is_div = 1'b1; tag = 2'd1; aux = 2'd1;
    @(negedge clk);
    check("t4.io_start_lane1", 64'(io_div_start), 64'd2);
    check("t4.oo_start_lane0", 64'(oo_div_start), 64'd1);
    next_cycle();
    @(negedge clk);
    check("t4.io_start_lane0", 64'(io_div_start), 64'd1);
    next_cycle();
    flush = 1'b1; unit_done = 2'b01; unit_result = {GARB, 64'h0000_0000_0000_0F0F};
    @(negedge clk);
    check("t4.io_kill", 64'(io_kill), 64'd1);
    check("t4.oo_kill", 64'(oo_kill), 64'd1);
    check("t4.io_in_ready", 64'(io_in_ready), 64'd0);
    check("t4.starts", 64'({io_div_start, io_sqrt_start, oo_div_start, oo_sqrt_start}), 64'd0);
    check("t4.io_busy_flush", 64'(io_busy), 64'd0);
    check_out("t4.io_no_out", 1'b0, 1'b0);
    check_out("t4.oo_no_out", 1'b1, 1'b0);
    next_cycle();
    flush = 1'b0; unit_done = 2'b00; in_valid = 1'b0;
    @(negedge clk);
    check("t4.io_busy_after", 64'(io_busy), 64'd0);
    check("t4.oo_busy_after", 64'(oo_busy), 64'd0);
    check("t4.io_in_ready_after", 64'(io_in_ready), 64'd1);
    check_out("t4.io_after", 1'b0, 1'b0);
    next_cycle();
    in_valid = 1'b1; is_div = 1'b0; tag = 2'd2; aux = 2'd0;
    q_io.push_back(mk(2'd2, 2'd0, 64'h0000_0000_0000_0555, 5'h03));
    @(negedge clk);
    check("t4.io_restart_lane0", 64'(io_sqrt_start), 64'd1);
    check("t4.oo_restart_lane0", 64'(oo_sqrt_start), 64'd1);
    next_cycle();
    in_valid = 1'b0;
    unit_done = 2'b01; unit_result = {GARB, 64'h0000_0000_0000_0555}; unit_status = {5'h1F, 5'h03};
    q_oo.push_back(mk(2'd2, 2'd0, 64'h0000_0000_0000_0555, 5'h03));
    @(negedge clk);
    check_out("t4.io_post_flush", 1'b0, 1'b1);
    check_out("t4.oo_post_flush", 1'b1, 1'b1);
    next_cycle();
    unit_done = 2'b00;

    // Test 5: asynchronous reset while a result sits in HOLD.
    in_valid = 1'b1; is_div = 1'b1; tag = 2'd3; aux = 2'd1;
    @(negedge clk);
    check("t5.io_start_lane1", 64'(io_div_start), 64'd2);
    q_io.push_back(mk(2'd3, 2'd1, 64'h0000_0000_0000_6666, 5'h06));
    next_cycle();
    in_valid = 1'b0; out_ready = 1'b0;
    unit_done = 2'b11; unit_result = {64'h0000_0000_0000_6666, 64'h0000_0000_0000_7777};
    unit_status = {5'h06, 5'h07};
    q_oo.push_back(mk(2'd3, 2'd1, 64'h0000_0000_0000_7777, 5'h07));
    @(negedge clk);
    check_out("t5.io_done_idle_ignored", 1'b0, 1'b1);
    check_out("t5.oo_done_idle_ignored", 1'b1, 1'b1);
    next_cycle();
    unit_done = 2'b00; unit_result = {GARB, GARB};
    @(negedge clk);
    check_out("t5.io_hold", 1'b0, 1'b1);
    check_out("t5.oo_hold", 1'b1, 1'b1);
    #2;
    rst_ni = 1'b0; unit_ready = 2'b10; in_valid = 1'b1;
    #1;
    q_io.delete(); q_oo.delete();
    check_out("t5.io_async_drop", 1'b0, 1'b0);
    check_out("t5.oo_async_drop", 1'b1, 1'b0);
    check("t5.io_busy_rst", 64'(io_busy), 64'd0);
    check("t5.io_in_ready_rst", 64'(io_in_ready), 64'd0);
    next_cycle();
    rst_ni = 1'b1;
    @(negedge clk);
    check("t5.io_in_ready_lane0_not_ready", 64'(io_in_ready), 64'd0);
    check("t5.oo_in_ready_lane0_not_ready", 64'(oo_in_ready), 64'd0);
    check("t5.no_starts", 64'({io_div_start, io_sqrt_start, oo_div_start, oo_sqrt_start}), 64'd0);
    check_out("t5.io_idle", 1'b0, 1'b0);
    next_cycle();
    unit_ready = 2'b11; tag = 2'd0; aux = 2'd2;
    q_io.push_back(mk(2'd0, 2'd2, 64'h0000_0000_0000_8888, 5'h08));
    @(negedge clk);
    check("t5.io_start_ptr0", 64'(io_div_start), 64'd1);
    check("t5.oo_start_ptr0", 64'(oo_div_start), 64'd1);
    next_cycle();
    in_valid = 1'b0; out_ready = 1'b1;
    unit_done = 2'b01; unit_result = {GARB, 64'h0000_0000_0000_8888}; unit_status = {5'h1F, 5'h08};
    q_oo.push_back(mk(2'd0, 2'd2, 64'h0000_0000_0000_8888, 5'h08));
    @(negedge clk);
    check_out("t5.io_ret_ptr0", 1'b0, 1'b1);
    check_out("t5.oo_ret", 1'b1, 1'b1);
    next_cycle();
    unit_done = 2'b00;
    @(negedge clk);
    check("end.q_io_empty", 64'(q_io.size()), 64'd0);
    check("end.q_oo_empty", 64'(q_oo.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
